// File: rtl/led_event_stretcher.sv
// led_event_stretcher
//   Turns short event flags from the vending-machine FSM (moneyin, buy_success,
//   buy_fail, refund, ...) into LED pulses long enough to be seen. Every 0->1
//   edge on a channel starts a fixed pulse train on that channel's LED. All
//   channels run independently and may start on the same clock edge.
//
//   Build option:
//     LED_BLINK_EN defined   : each event gives BLINKS blinks of HOLD_CYCLES on,
//                              separated by GAP_CYCLES off.
//     LED_BLINK_EN undefined : each event gives one HOLD_CYCLES pulse; the OFF
//                              phase is not built, BLINKS and GAP_CYCLES are
//                              ignored.
//
//   Ports:
//     clk      in   1    system clock
//     reset_n  in   1    asynchronous active-low reset
//     ev_in    in   NCH  event inputs, synchronous to clk (pulse or level)
//     led_out  out  NCH  stretched LED drive, active-high, registered
//     busy     out  NCH  channel not idle, registered

module led_event_stretcher #(
  parameter int NCH         = 4,
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 15_000_000,
  parameter int BLINKS      = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [NCH-1:0] ev_in,
  output logic [NCH-1:0] led_out,
  output logic [NCH-1:0] busy
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  // Counters are loaded with N-1 and run down to 0, so a phase lasts N cycles.
  localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD_CYCLES - 1);

`ifdef LED_BLINK_EN
  localparam int            BW          = $clog2(BLINKS + 1);
  localparam logic [CW-1:0] GAP_RELOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] LEFT_RELOAD = BW'(BLINKS - 1);
`endif

  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || BLINKS < 1) begin : g_bad_params
    $error("led_event_stretcher: HOLD_CYCLES, GAP_CYCLES and BLINKS must all be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  logic [NCH-1:0] ev_q;
  logic [NCH-1:0] trig;

  // Previous-cycle copy of the inputs for edge detection. It resets to all
  // ones so that an input already high when reset is released is not taken
  // as a fresh event; only a later 0->1 edge triggers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_q <= '1;
    end else begin
      ev_q <= ev_in;
    end
  end

  assign trig = ev_in & ~ev_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
`ifdef LED_BLINK_EN
    logic [BW-1:0] left;
`endif
    logic          led_q;
    logic          busy_q;

    // Per-channel sequencer. led_q and busy_q are updated together with the
    // state so they always reflect the state being entered, which makes the
    // LED rise on the edge right after the trigger and keeps the outputs
    // glitch-free. A trigger wins over counter expiry and always restarts a
    // full sequence, so a retrigger during ON keeps the LED high without a gap.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state  <= IDLE;
        cnt    <= '0;
`ifdef LED_BLINK_EN
        left   <= '0;
`endif
        led_q  <= 1'b0;
        busy_q <= 1'b0;
      end else if (trig[i]) begin
        state  <= ON;
        cnt    <= HOLD_RELOAD;
`ifdef LED_BLINK_EN
        left   <= LEFT_RELOAD;
`endif
        led_q  <= 1'b1;
        busy_q <= 1'b1;
      end else begin
        case (state)
          ON: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
`ifdef LED_BLINK_EN
            end else if (left != '0) begin
              state <= OFF;
              cnt   <= GAP_RELOAD;
              led_q <= 1'b0;
`endif
            end else begin
              state  <= IDLE;
              led_q  <= 1'b0;
              busy_q <= 1'b0;
            end
          end
`ifdef LED_BLINK_EN
          OFF: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else begin
              state <= ON;
              cnt   <= HOLD_RELOAD;
              left  <= left - BW'(1);
              led_q <= 1'b1;
            end
          end
`endif
          default: begin
            state  <= IDLE;
            led_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end

    assign led_out[i] = led_q;
    assign busy[i]    = busy_q;
  end

endmodule
